// File: rtl/invsqrt_pkg.sv
// rtl/invsqrt_pkg.sv - shared constants, FSM states and operand classes for the inverse-sqrt sequencer
package invsqrt_pkg;

  localparam logic [31:0] MAGIC_DEFAULT = 32'h5F3759DF;
  localparam logic [31:0] ONE_HALF_F32  = 32'h3FC00000;
  localparam logic [31:0] POS_INF       = 32'h7F800000;
  localparam logic [31:0] NEG_INF       = 32'hFF800000;
  localparam logic [31:0] QNAN          = 32'h7FC00000;

  typedef enum logic [3:0] {
    IDLE, SEED, M1, WAIT_M1, M2, WAIT_M2, S, WAIT_S, M3, WAIT_M3, DONE
  } state_t;

  typedef enum logic [2:0] {
    NORMAL, PZERO, NZERO, NEG, NAN, PINF
  } xclass_t;

endpackage

// File: rtl/invsqrt_seed.sv
// rtl/invsqrt_seed.sv - combinational bit-trick seed, half operand and operand classification
module invsqrt_seed
  import invsqrt_pkg::*;
#(
  parameter logic [31:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic [31:0] x,
  output logic [31:0] y0,
  output logic [31:0] hx,
  output xclass_t     xclass
);

  logic [7:0] e;
  assign e = x[30:23];

  always_comb begin
    y0 = MAGIC - (x >> 1);
    // exponent 1 would become a denormal half; flush it to zero like exponent 0
    hx = (e <= 8'd1) ? 32'h0 : {x[31], e - 8'd1, x[22:0]};
    if (e == 8'hFF && x[22:0] != 23'd0)
      xclass = NAN;
    else if (x == 32'h80000000)
      xclass = NZERO;
    else if (x[31])
      xclass = NEG;
    else if (e == 8'hFF)
      xclass = PINF;
    else if (e == 8'd0)
      xclass = PZERO;
    else
      xclass = NORMAL;
  end

endmodule

// File: rtl/invsqrt_newton_seq.sv
// rtl/invsqrt_newton_seq.sv - Newton-Raphson 1/sqrt(x) sequencer driving one shared FP multiplier and subtractor
module invsqrt_newton_seq
  import invsqrt_pkg::*;
#(
  parameter int          ITER  = 1,
  parameter logic [31:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DataIn,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] DataOut,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_go,
  input  logic [31:0] mul_res,
  input  logic        mul_done,
  output logic [31:0] sub_a,
  output logic [31:0] sub_b,
  output logic        sub_go,
  input  logic [31:0] sub_res,
  input  logic        sub_done
);

  localparam logic [1:0] ITER_L = 2'(ITER);

  state_t      state;
  logic [31:0] x;
  logic [31:0] y;
  logic [1:0]  cnt;
  logic [31:0] y0;
  logic [31:0] hx;
  xclass_t     xclass;
  logic [31:0] bypass_val;

  invsqrt_seed #(.MAGIC(MAGIC)) u_seed (
    .x      (x),
    .y0     (y0),
    .hx     (hx),
    .xclass (xclass)
  );

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE) && !rst;

  always_comb begin
    bypass_val = QNAN;
    case (xclass)
      PZERO:   bypass_val = POS_INF;
      NZERO:   bypass_val = NEG_INF;
      PINF:    bypass_val = 32'h0;
      default: bypass_val = QNAN;
    endcase
  end

  // x stays registered for the whole operation, so hx from the seed block is valid in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= 32'h0;
      y         <= 32'h0;
      cnt       <= 2'd0;
      DataOut   <= 32'h0;
      out_valid <= 1'b0;
      mul_a     <= 32'h0;
      mul_b     <= 32'h0;
      mul_go    <= 1'b0;
      sub_a     <= 32'h0;
      sub_b     <= 32'h0;
      sub_go    <= 1'b0;
    end else begin
      mul_go <= 1'b0;
      sub_go <= 1'b0;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          x     <= DataIn;
          state <= SEED;
        end
        SEED: if (xclass == NORMAL) begin
          y      <= y0;
          mul_a  <= y0;
          mul_b  <= y0;
          mul_go <= 1'b1;
          state  <= M1;
        end else begin
          DataOut   <= bypass_val;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        M1: state <= WAIT_M1;
        WAIT_M1: if (mul_done) begin
          mul_a  <= mul_res;
          mul_b  <= hx;
          mul_go <= 1'b1;
          state  <= M2;
        end
        M2: state <= WAIT_M2;
        WAIT_M2: if (mul_done) begin
          sub_a  <= ONE_HALF_F32;
          sub_b  <= mul_res;
          sub_go <= 1'b1;
          state  <= S;
        end
        S: state <= WAIT_S;
        WAIT_S: if (sub_done) begin
          mul_a  <= y;
          mul_b  <= sub_res;
          mul_go <= 1'b1;
          state  <= M3;
        end
        M3: state <= WAIT_M3;
        WAIT_M3: if (mul_done) begin
          y   <= mul_res;
          cnt <= cnt + 2'd1;
          if (cnt + 2'd1 == ITER_L) begin
            DataOut   <= mul_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            mul_a  <= mul_res;
            mul_b  <= mul_res;
            mul_go <= 1'b1;
            state  <= M1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          cnt       <= 2'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_invsqrt_newton_seq.sv
// tb/tb_invsqrt_newton_seq.sv - randomized self-checking bench with behavioural FP units and reference model
module tb_invsqrt_newton_seq;

  localparam int  ITER = 2;
  localparam real TOL  = (ITER == 1) ? 2.0e-3 : 2.0e-5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] DataIn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] DataOut;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [31:0] mul_a, mul_b, mul_res;
  logic        mul_go, mul_done;
  logic [31:0] sub_a, sub_b, sub_res;
  logic        sub_go, sub_done;

  int errors = 0;
  int checks = 0;

  int          n_mul, n_sub, lat_sum, force_lat;
  int          mcnt, scnt;
  logic [31:0] mpend, spend, first_mul_a;
  bit          inj_go_done, inj_sub_spur, spur_next;

  always #5 clk = ~clk;

  invsqrt_newton_seq #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst), .DataIn(DataIn), .in_valid(in_valid), .in_ready(in_ready),
    .DataOut(DataOut), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_go(mul_go), .mul_res(mul_res), .mul_done(mul_done),
    .sub_a(sub_a), .sub_b(sub_b), .sub_go(sub_go), .sub_res(sub_res), .sub_done(sub_done)
  );

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    int e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    d = {b[31], 11'(e + 896), b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // truncating conversion; the bench units and the model share it so results are bit-comparable
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'b0};
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) - f2r(b));
  endfunction

  function automatic logic [31:0] model_inv(input logic [31:0] xv);
    logic [7:0]  e;
    logic [31:0] y, hx, t;
    e = xv[30:23];
    if (e == 8'hFF && xv[22:0] != 0) return 32'h7FC00000;
    if (xv == 32'h80000000) return 32'hFF800000;
    if (xv[31]) return 32'h7FC00000;
    if (e == 8'hFF) return 32'h00000000;
    if (e == 8'h00) return 32'h7F800000;
    y  = 32'h5F3759DF - (xv >> 1);
    hx = (e < 8'd2) ? 32'h0 : r2f(f2r(xv) * 0.5);
    for (int i = 0; i < ITER; i++) begin
      t = fmul(y, y);
      t = fmul(t, hx);
      t = fsub(32'h3FC00000, t);
      y = fmul(y, t);
    end
    return y;
  endfunction

  function automatic real rel_err(input logic [31:0] xv, input logic [31:0] res);
    real ref_v, d;
    ref_v = 1.0 / $sqrt(f2r(xv));
    d = (f2r(res) - ref_v) / ref_v;
    return (d < 0.0) ? -d : d;
  endfunction

  // FP units: one op outstanding at a time, done one cycle wide after 1..6 cycles
  initial begin
    mul_done = 0; sub_done = 0; mul_res = 0; sub_res = 0;
    mcnt = 0; scnt = 0; spur_next = 0; n_mul = 0; n_sub = 0; lat_sum = 0;
    forever begin
      @(negedge clk);
      mul_done = 0;
      sub_done = 0;
      if (spur_next) begin
        sub_done = 1; sub_res = 32'h12345678; spur_next = 0;
      end
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin mul_done = 1; mul_res = mpend; end
      end
      if (scnt > 0) begin
        scnt--;
        if (scnt == 0) begin sub_done = 1; sub_res = spend; end
      end
      if (mul_go) begin
        if (n_mul == 0) first_mul_a = mul_a;
        n_mul++;
        mpend = fmul(mul_a, mul_b);
        mcnt = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
        if (inj_sub_spur) begin
          inj_sub_spur = 0; spur_next = 1;
          if (mcnt < 2) mcnt = 2;
        end
        lat_sum += mcnt;
        if (inj_go_done) begin
          inj_go_done = 0; mul_done = 1; mul_res = 32'hDEADBEEF;
        end
      end
      if (sub_go) begin
        n_sub++;
        spend = fsub(sub_a, sub_b);
        scnt = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
        lat_sum += scnt;
      end
    end
  end

  task automatic start_op(input logic [31:0] xv);
    int k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL accept_timeout in_ready=%b required=1", in_ready); end
    n_mul = 0; n_sub = 0; lat_sum = 0;
    DataIn = xv; in_valid = 1;
    @(negedge clk);
    in_valid = 0; DataIn = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 1000) begin @(negedge clk); lat++; end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL out_valid_timeout out_valid=%b required=1", out_valid); end
  endtask

  task automatic release_out();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL release out_valid,in_ready=%b required=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0; DataIn = 0; force_lat = 0;
    inj_go_done = 0; inj_sub_spur = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, mul_go, sub_go} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b required=00000", {in_ready, out_valid, busy, mul_go, sub_go});
    end
    checks++;
    if ({DataOut, mul_a, mul_b, sub_a, sub_b} !== 160'h0) begin
      errors++; $display("FAIL reset_data DataOut=%h mul_a=%h mul_b=%h sub_a=%h sub_b=%h required=0",
                         DataOut, mul_a, mul_b, sub_a, sub_b);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_known();
    logic [31:0] xs [2]    = '{32'h40800000, 32'h3F800000};
    logic [31:0] seeds [2] = '{32'h3EF759DF, 32'h3F7759DF};
    logic [31:0] ideal [2] = '{32'h3F000000, 32'h3F800000};
    int lat;
    for (int i = 0; i < 2; i++) begin
      start_op(xs[i]);
      wait_out(lat);
      checks++;
      if (first_mul_a !== seeds[i]) begin errors++; $display("FAIL known_seed got=%h required=%h", first_mul_a, seeds[i]); end
      checks++;
      if (n_mul != 3 * ITER || n_sub != ITER) begin
        errors++; $display("FAIL known_go_counts mul=%0d sub=%0d required=%0d,%0d", n_mul, n_sub, 3 * ITER, ITER);
      end
      checks++;
      if (DataOut !== model_inv(xs[i])) begin errors++; $display("FAIL known_exact got=%h required=%h", DataOut, model_inv(xs[i])); end
      checks++;
      if ((f2r(DataOut) - f2r(ideal[i])) / f2r(ideal[i]) > TOL || (f2r(ideal[i]) - f2r(DataOut)) / f2r(ideal[i]) > TOL) begin
        errors++; $display("FAIL known_tol got=%h near=%h", DataOut, ideal[i]);
      end
      checks++;
      if (lat != 2 + 4 * ITER + lat_sum) begin errors++; $display("FAIL known_latency got=%0d required=%0d", lat, 2 + 4 * ITER + lat_sum); end
      release_out();
    end
  endtask

  task automatic test_specials();
    logic [31:0] xs [7] = '{32'h00000000, 32'h80000000, 32'hC0000000, 32'h7FC00001,
                            32'h7F800000, 32'h00000001, 32'hFF800000};
    logic [31:0] ex [7] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
                            32'h00000000, 32'h7F800000, 32'h7FC00000};
    int lat;
    for (int i = 0; i < 7; i++) begin
      start_op(xs[i]);
      wait_out(lat);
      checks++;
      if (DataOut !== ex[i] || lat != 2 || n_mul + n_sub != 0) begin
        errors++; $display("FAIL special x=%h got=%h lat=%0d gos=%0d required=%h lat=2 gos=0",
                           xs[i], DataOut, lat, n_mul + n_sub, ex[i]);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [31:0] xv;
    int lat;
    for (int i = 0; i < 8; i++) begin
      xv = {1'b0, 8'($urandom_range(4, 250)), 23'($urandom)};
      start_op(xv);
      wait_out(lat);
      checks++;
      if (DataOut !== model_inv(xv) || rel_err(xv, DataOut) > TOL) begin
        errors++; $display("FAIL random x=%h got=%h required=%h", xv, DataOut, model_inv(xv));
      end
      checks++;
      if (n_mul != 3 * ITER || n_sub != ITER || lat != 2 + 4 * ITER + lat_sum) begin
        errors++; $display("FAIL random_timing mul=%0d sub=%0d lat=%0d required=%0d,%0d,%0d",
                           n_mul, n_sub, lat, 3 * ITER, ITER, 2 + 4 * ITER + lat_sum);
      end
      release_out();
    end
    xv = 32'h00800000;
    start_op(xv);
    wait_out(lat);
    checks++;
    if (DataOut !== model_inv(xv)) begin errors++; $display("FAIL min_normal got=%h required=%h", DataOut, model_inv(xv)); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int lat;
    start_op(32'h42C80000);
    wait_out(lat);
    held = DataOut;
    checks++;
    if (held !== model_inv(32'h42C80000)) begin errors++; $display("FAIL bp_value got=%h required=%h", held, model_inv(32'h42C80000)); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (DataOut !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d DataOut=%h out_valid=%b in_ready=%b required=%h,1,0",
                           i, DataOut, out_valid, in_ready, held);
      end
    end
    release_out();
  endtask

  task automatic test_rst_midop();
    int k = 0;
    bit bad = 0;
    int lat;
    force_lat = 6;
    start_op(32'h41200000);
    while (n_mul < 2 && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || mul_go || sub_go || busy || !in_ready) bad = 1;
    end
    checks++;
    if (bad || n_mul != 2) begin
      errors++; $display("FAIL rst_midop bad=%0d mul_issued=%0d required=0,2", bad, n_mul);
    end
    force_lat = 0;
    start_op(32'h40490FDB);
    wait_out(lat);
    checks++;
    if (DataOut !== model_inv(32'h40490FDB) || n_mul != 3 * ITER) begin
      errors++; $display("FAIL after_rst got=%h mul=%0d required=%h,%0d", DataOut, n_mul, model_inv(32'h40490FDB), 3 * ITER);
    end
    release_out();
  endtask

  task automatic test_spurious();
    int lat;
    inj_sub_spur = 1;
    inj_go_done = 1;
    start_op(32'h3E800000);
    wait_out(lat);
    checks++;
    if (DataOut !== model_inv(32'h3E800000) || rel_err(32'h3E800000, DataOut) > TOL) begin
      errors++; $display("FAIL spurious got=%h required=%h", DataOut, model_inv(32'h3E800000));
    end
    checks++;
    if (n_mul != 3 * ITER || n_sub != ITER || lat != 2 + 4 * ITER + lat_sum) begin
      errors++; $display("FAIL spurious_timing mul=%0d sub=%0d lat=%0d required=%0d,%0d,%0d",
                         n_mul, n_sub, lat, 3 * ITER, ITER, 2 + 4 * ITER + lat_sum);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_known();
    test_specials();
    test_random();
    test_backpressure();
    test_rst_midop();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
